// File: rtl/div_pkg.sv
// Shared definitions for the round-robin divider scheduler.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [31:0] DBZ_QUOTIENT = '1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping.
module rr_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    localparam int SW = ID_W + 1;

    logic [SW-1:0] slot;
    logic          found;

    // One extra bit holds last_grant+k before folding it back below NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        slot      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            slot = {1'b0, last_grant} + SW'(k);
            if (slot >= SW'(NUM_REQ)) begin
                slot = slot - SW'(NUM_REQ);
            end
            if (!found && req[slot[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant[slot[ID_W-1:0]]  = 1'b1;
                grant_idx              = slot[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/div_sched_rr.sv
// Shares one iterative divider core among NUM_REQ requesters, round-robin,
// with local divide-by-zero handling and a watchdog on the core.
module div_sched_rr
    import div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ),
    parameter int TIMEOUT = 2 * WIDTH + 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_dbz,
    output logic                     rsp_timeout,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder,
    input  logic                     div_done,
    output logic                     busy
);

    localparam int WD_W = clog2(TIMEOUT) + 1;

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;
    logic [WD_W-1:0]    wd;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*WIDTH +: WIDTH];
                sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Acceptance is only ever offered from IDLE, so jobs never overlap.
    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= ID_W'(NUM_REQ - 1);
            wd            <= '0;
            div_start     <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dbz       <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        last_grant   <= grant_idx;
                        rsp_id       <= grant_idx;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            rsp_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
                            rsp_remainder <= sel_dividend;
                            rsp_dbz       <= 1'b1;
                            rsp_timeout   <= 1'b0;
                            rsp_valid     <= 1'b1;
                            state         <= RESP;
                        end else begin
                            div_start <= 1'b1;
                            state     <= START;
                        end
                    end
                end
                START: begin
                    div_start <= 1'b0;
                    wd        <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last watchdog cycle still wins.
                    if (div_done) begin
                        state <= CAPTURE;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        rsp_quotient  <= '0;
                        rsp_remainder <= '0;
                        rsp_dbz       <= 1'b0;
                        rsp_timeout   <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                CAPTURE: begin
                    // Core results settle one cycle after its done pulse.
                    rsp_quotient  <= div_quotient;
                    rsp_remainder <= div_remainder;
                    rsp_dbz       <= 1'b0;
                    rsp_timeout   <= 1'b0;
                    rsp_valid     <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_sched_rr.md
Name: div_sched_rr

Overview:
- Round-robin scheduler that shares one iterative divider core among NUM_REQ requesters.
- Each requester presents a job on a valid/ready channel. The block grants one job at a time and sequences the core (start pulse, wait, capture).
- Results return on a single tagged response channel with backpressure.
- Divide-by-zero is handled locally without using the core. A watchdog aborts jobs when the core never completes.

Parameters:
- WIDTH, 8: operand/result bit width; must match the divider core.
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, 2: response tag width, equal to clog2(NUM_REQ).
- TIMEOUT, 2*WIDTH+8: maximum cycles in WAIT before abort.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester job valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- req_dividend  in  NUM_REQ*WIDTH  packed dividends; requester i at [i*WIDTH +: WIDTH].
- req_divisor  in  NUM_REQ*WIDTH  packed divisors, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester this response belongs to.
- rsp_quotient  out  WIDTH  quotient.
- rsp_remainder  out  WIDTH  remainder.
- rsp_dbz  out  1  job had a zero divisor.
- rsp_timeout  out  1  job aborted by the watchdog.
- div_start  out  1  one-cycle start pulse to the core.
- div_dividend  out  WIDTH  operand to the core; held stable from START through CAPTURE.
- div_divisor  out  WIDTH  operand to the core; held stable from START through CAPTURE.
- div_quotient  in  WIDTH  core result.
- div_remainder  in  WIDTH  core result.
- div_done  in  1  core completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async on rst_n low): state=IDLE; all outputs 0; operand/result registers 0; watchdog counter 0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req_valid, grant g = first set bit searching upward from last_grant+1, with wrap-around.
  - req_ready[g]=1 combinationally in this cycle only; the handshake completes this cycle.
  - Latch operands and id=g; set last_grant=g.
  - If divisor==0: next=RESP with quotient={WIDTH{1'b1}}, remainder=dividend, dbz=1.
  - Otherwise next=START.
- State START: div_start=1 for exactly one cycle; clear watchdog; next=WAIT.
- State WAIT:
  - Watchdog increments each cycle.
  - div_done=1: next=CAPTURE.
  - Watchdog reaches TIMEOUT-1 without div_done: next=RESP with quotient=0, remainder=0, timeout=1.
  - div_done in the same cycle as timeout: done wins.
- State CAPTURE: register div_quotient/div_remainder (sampled one cycle after div_done, because core outputs settle after its done edge); next=RESP.
- State RESP:
  - rsp_valid=1; all rsp_* fields are registered and stable until rsp_valid && rsp_ready.
  - On that handshake: next=IDLE, and rsp_valid drops the following cycle.
- req_ready is 0 in every state except IDLE. There is no back-to-back acceptance; minimum of one IDLE cycle between jobs.
- div_done outside WAIT is ignored.
- Latency for a non-zero divisor, with accept at cycle T and core latency D cycles from start to done: div_start at T+1, done at T+1+D, rsp_valid at T+3+D.
- Latency for a zero divisor: rsp_valid at T+1; div_start is never asserted.
- Fairness: a continuously valid requester is served within NUM_REQ grants.
- Reset mid-operation: the job is dropped with no response and state returns to IDLE. The core has no reset, so a stale div_done may arrive later; it is ignored outside WAIT, and a core that swallows the next start is recovered by the watchdog.
- Arithmetic: the block does no sign handling; operands pass through unmodified. The divide-by-zero result is fixed as above regardless of the core's signed mode.

Decomposition:
- Shared package div_pkg contains:
  - state enum: IDLE, START, WAIT, CAPTURE, RESP;
  - DBZ_QUOTIENT constant (all ones);
  - clog2 helper function.
- One sub-module, rr_arbiter:
  - parameter NUM_REQ;
  - inputs: req vector, last_grant pointer;
  - outputs: one-hot grant, encoded grant index;
  - purely combinational; the pointer stays in div_sched_rr.

Test Plan (WIDTH=8, NUM_REQ=4, core model with D=9):
- Requester 0 only, 200/7 -> rsp_id=0, quotient=28, remainder=4, dbz=0, timeout=0; exactly one div_start pulse; rsp_valid 12 cycles after accept.
- All four req_valid high from reset with distinct jobs (100/3, 50/5, 9/2, 255/16) -> grant order 0,1,2,3; responses (33,1), (10,0), (4,1), (15,15) with matching rsp_id; then re-assert req 0 and 2 -> order 2? No: the pointer is at 3, so the order is 0 then 2.
- Requester 2, 55/0 -> rsp_valid at accept+1, quotient=0xFF, remainder=55, dbz=1; div_start never asserted.
- rsp_ready held low 5 cycles during RESP with other requesters valid -> rsp_* fields unchanged, req_ready all 0; completes on the 6th cycle.
- Core model never pulses div_done, TIMEOUT=20 -> rsp_timeout=1, quotient=0, remainder=0, rsp_valid 22 cycles after accept; the next job proceeds normally.
- rst_n low during WAIT with the model's div_done arriving 3 cycles later -> outputs 0 immediately; late div_done ignored; after reset, requester 0 granted first and result correct.
